// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: expands one instruction at a time into T-state control strobes for the ALU datapath
module alu_control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] opcode,
  input  logic [7:0] operand,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_data,
  output logic       load_bus,
  output logic       nLa,
  output logic       nLb,
  output logic       Ea,
  output logic       Eu,
  output logic       sub,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       done,
  output logic       halted,
  output logic       err,
  output logic [7:0] instr_count
);
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_LDB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OUT = 3'b101;
  localparam logic [2:0] OP_HLT = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;
  typedef enum logic [2:0] {IDLE, T1, T2, T3, HALT} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] opnd_q, out_data_q, count_q;
  logic out_valid_q, done_q, err_q;
  logic accept, last, loads, alu_op;
  assign accept = instr_valid && state_q == IDLE;
  assign loads  = op_q == OP_LDA || op_q == OP_LDB;
  assign alu_op = op_q == OP_ADD || op_q == OP_SUB;
  assign last   = (state_q == T1 && !loads && !alu_op) || (state_q == T2 && loads) || state_q == T3;
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: HLT parks in HALT, otherwise walk T-states until the opcode's last one
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? (opcode == OP_HLT ? HALT : T1) : IDLE;
      T1:   state_d = last ? IDLE : T2;
      T2:   state_d = last ? IDLE : T3;
      T3:   state_d = IDLE;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  // control strobes decoded from registered state and latched opcode only
  always_comb begin
    load_bus    = (state_q == T1 || state_q == T2) && (loads || alu_op);
    nLa         = !((state_q == T2 && op_q == OP_LDA) || state_q == T3);
    nLb         = !(state_q == T2 && (op_q == OP_LDB || alu_op));
    Ea          = state_q == T1 && op_q == OP_OUT;
    Eu          = state_q == T3;
    sub         = state_q == T3 && op_q == OP_SUB;
    bus_data    = load_bus ? opnd_q : 8'h00;
    instr_ready = state_q == IDLE;
    halted      = state_q == HALT;
  end
  // instruction latch, completion pulses, OUT capture, sticky error and counter
  always_ff @(posedge clk)
    if (!rst_n) begin
      op_q        <= 3'b000;
      opnd_q      <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= 8'h00;
    end else begin
      done_q      <= last;
      out_valid_q <= last && op_q == OP_OUT;
      count_q     <= count_q + {7'd0, last};
      if (accept) begin
        op_q   <= opcode;
        opnd_q <= operand;
        if (opcode == OP_RSV) err_q <= 1'b1;
      end
      if (state_q == T1 && op_q == OP_OUT) out_data_q <= bus_in;
    end
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = count_q;
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: directed and randomized checks of the sequencer against a per-opcode T-state table
module tb_alu_control_sequencer;
  logic clk = 1'b0;
  logic rst_n, instr_valid, instr_ready, load_bus, nLa, nLb, Ea, Eu, sub, out_valid, done, halted, err;
  logic [2:0] opcode;
  logic [7:0] operand, bus_in, bus_data, out_data, instr_count;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_count, exp_out;
  logic exp_err;

  always #5 clk = ~clk;

  alu_control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .operand(operand), .bus_in(bus_in), .bus_data(bus_data),
    .load_bus(load_bus), .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eu(Eu), .sub(sub),
    .out_data(out_data), .out_valid(out_valid), .done(done), .halted(halted),
    .err(err), .instr_count(instr_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // number of T-states each opcode occupies
  function automatic int nts(input logic [2:0] op);
    return (op == 3'd3 || op == 3'd4) ? 3 : (op == 3'd1 || op == 3'd2) ? 2 : 1;
  endfunction

  // expected {load_bus,nLa,nLb,Ea,Eu,sub} in T-state t of opcode op
  function automatic logic [5:0] ctl(input logic [2:0] op, input int t);
    case (op)
      3'd1: return t == 1 ? 6'b111000 : 6'b101000;
      3'd2: return t == 1 ? 6'b111000 : 6'b110000;
      3'd3: return t == 1 ? 6'b111000 : t == 2 ? 6'b110000 : 6'b001010;
      3'd4: return t == 1 ? 6'b111000 : t == 2 ? 6'b110000 : 6'b001011;
      3'd5: return 6'b011100;
      default: return 6'b011000;
    endcase
  endfunction

  task automatic check_inv;
    chk("invariant", {~(~nLa & ~nLb), 1'b0, ({1'b0, load_bus} + {1'b0, Ea} + {1'b0, Eu}) <= 2'd1, !sub || Eu}, 4'b1011);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_strobes"}, {load_bus, nLa, nLb, Ea, Eu, sub}, 6'b011000);
    chk({tag, "_bus_data"}, bus_data, 8'h00);
    check_inv();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_count = 8'h00;
    exp_out = 8'h00;
    exp_err = 1'b0;
    check_idle("rst");
    chk("rst_ready", instr_ready, 1);
    chk("rst_flags", {out_valid, done, halted, err}, 4'b0000);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_count", instr_count, 8'h00);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [7:0] opnd, input logic [7:0] bus, input bit hold);
    logic [5:0] c;
    chk("accept_ready", instr_ready, 1);
    instr_valid = 1'b1;
    opcode = op;
    operand = opnd;
    bus_in = bus;
    step();
    if (!hold) begin
      instr_valid = 1'b0;
      opcode = 3'($urandom);
      operand = 8'($urandom);
    end
    for (int t = 1; t <= nts(op); t++) begin
      c = ctl(op, t);
      chk("ctl", {load_bus, nLa, nLb, Ea, Eu, sub}, c);
      chk("bus_data", bus_data, c[5] ? opnd : 8'h00);
      chk("busy_ready", instr_ready, 0);
      chk("busy_pulses", {done, out_valid}, 2'b00);
      check_inv();
      step();
      bus_in = 8'($urandom);
    end
    exp_count = exp_count + 8'd1;
    if (op == 3'd5) exp_out = bus;
    if (op == 3'd7) exp_err = 1'b1;
    chk("done", done, 1);
    chk("out_valid", out_valid, op == 3'd5);
    chk("count", instr_count, exp_count);
    chk("out_data", out_data, exp_out);
    chk("err", err, exp_err);
    chk("done_ready", instr_ready, 1);
    check_idle("done");
  endtask

  initial begin
    logic [2:0] op;
    bit hold;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    opcode = 3'd0;
    operand = 8'h00;
    bus_in = 8'h00;
    do_reset();
    run_instr(3'd1, 8'h2A, 8'h00, 0);
    step();
    chk("post_done", done, 0);
    run_instr(3'd3, 8'h05, 8'h00, 1);
    run_instr(3'd4, 8'h03, 8'h00, 0);
    chk("count_two_more", instr_count, 8'd3);
    step();
    run_instr(3'd5, 8'h00, 8'hC3, 0);
    step();
    chk("out_valid_after", out_valid, 0);
    chk("out_data_hold", out_data, 8'hC3);
    run_instr(3'd7, 8'h11, 8'h00, 0);
    step();
    chk("err_sticky", err, 1);
    instr_valid = 1'b1;
    opcode = 3'd6;
    step();
    opcode = 3'd1;
    repeat (4) begin
      chk("halted", halted, 1);
      chk("halt_ready", instr_ready, 0);
      chk("halt_done", done, 0);
      chk("halt_count", instr_count, exp_count);
      check_idle("halt");
      step();
    end
    do_reset();
    repeat (40) begin
      op = 3'($urandom_range(0, 6));
      if (op == 3'd6) op = 3'd7;
      hold = 1'($urandom_range(0, 1));
      run_instr(op, 8'($urandom), 8'($urandom), hold);
      if (!hold) begin
        repeat ($urandom_range(1, 2)) begin
          step();
          chk("gap_done", {done, out_valid}, 2'b00);
          check_idle("gap");
        end
      end
    end
    do_reset();
    repeat (256) run_instr(3'd0, 8'h00, 8'h00, 0);
    chk("wrap_count", instr_count, 8'h00);
    instr_valid = 1'b1;
    opcode = 3'd3;
    operand = 8'h05;
    step();
    instr_valid = 1'b0;
    step();
    chk("abort_t2", {load_bus, nLa, nLb, Ea, Eu, sub}, ctl(3'd3, 2));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_nLb", nLb, 1);
    check_idle("abort");
    chk("abort_done", {done, out_valid}, 2'b00);
    chk("abort_count", instr_count, 8'h00);
    step();
    chk("abort_done2", {done, out_valid}, 2'b00);
    chk("abort_count2", instr_count, 8'h00);
    check_idle("abort2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
